ir_sense: RTL and testbench
===========================

# ir_sense

Front end of the IR wall-following path: periodically pulses the IR emitters, runs a request/ready handshake against the shared A2D to sample the left and right IR receivers, averages 2^AVG_LOG2 samples per side, and applies hysteretic open-wall detection. Its registered outputs (`lft_IR`, `rght_IR`, `lft_opn`, `rght_opn`) drive the IR fusion math directly, which turns them into a heading adjustment. `IR_vld` marks each fresh set.

## Interface
Parameters:
- `PERIOD`, 1024: cycles between measurement rounds (tick period)
- `SETTLE`, 64: cycles emitter is on before first conversion
- `AVG_LOG2`, 2: log2 of samples averaged per side (1..4)
- `LFT_CHNL`, 3'd3: A2D channel for left receiver
- `RGHT_CHNL`, 3'd0: A2D channel for right receiver
- `OPN_SET`, 12'h200: average strictly below this sets open
- `OPN_CLR`, 12'h300: average at or above this clears open (must be > `OPN_SET`)

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `en` in 1: enables measurement rounds
- `IR_en` out 1: emitter enable
- `a2d_req` out 1: conversion request
- `a2d_chnl` out 3: channel for current request
- `a2d_rdy` in 1: conversion done; `a2d_res` valid this cycle
- `a2d_res` in 12: conversion result, unsigned
- `lft_IR` out 12: left averaged reading
- `rght_IR` out 12: right averaged reading
- `lft_opn` out 1: left open flag
- `rght_opn` out 1: right open flag
- `IR_vld` out 1: one-cycle pulse on output update

## Operation
- Period counter: counts 0..PERIOD-1 while `en`=1, held at 0 while `en`=0; tick when count = PERIOD-1.
- FSM states: IDLE, SETTLE, REQ, NEXT, DONE.
- IDLE: `IR_en`=0, `a2d_req`=0. Tick and `en` -> SETTLE; clear accumulators and sample counter.
- SETTLE: `IR_en`=1; count SETTLE cycles -> REQ with channel = `LFT_CHNL`. `en` falls -> IDLE immediately, `IR_en` drops next cycle.
- REQ: `a2d_req`=1, `a2d_chnl` stable; hold until `a2d_rdy`=1. On that cycle add `a2d_res` to the side's accumulator -> NEXT.
- NEXT: `a2d_req`=0 for exactly one cycle. Alternate L,R,L,R...; after 2·2^AVG_LOG2 conversions -> DONE, else -> REQ with the other channel. If `en`=0 here -> IDLE, outputs not updated.
- `en` falling during REQ does not abort; handshake completes, then NEXT exits to IDLE.
- DONE: `lft_IR`/`rght_IR` <= accumulator >> AVG_LOG2 (truncating); update open flags; `IR_vld`=1; `IR_en`=0; -> IDLE.
- Accumulators are 12+AVG_LOG2 bits unsigned, no overflow possible.
- Open hysteresis per side: avg < OPN_SET -> 1; avg >= OPN_CLR -> 0; otherwise hold previous value.
- Tick arriving outside IDLE is dropped, not queued.
- `a2d_rdy` outside REQ is ignored.

## Timing
- Reset values: `IR_en`=0, `a2d_req`=0, `a2d_chnl`=`LFT_CHNL`, `lft_IR`=`rght_IR`=0, `lft_opn`=`rght_opn`=1 (fusion neutral), `IR_vld`=0; FSM IDLE, counters 0.
- Tick cycle N -> `IR_en` high from N+1, first `a2d_req` at N+1+SETTLE.
- With `a2d_rdy` returned k cycles after `req`, one conversion = k+2 cycles (REQ k+1, NEXT 1).
- Outputs and `IR_vld` change on the same edge, one cycle after the last NEXT; outputs then hold until the next DONE.
- `rst` mid-round: everything returns to reset values asynchronously; no partial update.

## Structure
- Package `ir_pkg`: FSM state enum, default channel constants.
- Sub-module `ir_hyst` (12-bit average in, update strobe, open flag out with set/clear thresholds), instantiated per side.

## Test plan
- Reset, `en`=1, A2D model returns 12'h800 both channels, k=3 -> `IR_vld` at tick+1+64+8·5; `lft_IR`=`rght_IR`=12'h800, both opn=0.
- Left samples 12'h100,12'h101,12'h102,12'h103 -> `lft_IR`=12'h101 (truncated), `lft_opn`=1.
- Hysteresis: left avg sequence 12'h1FF, 12'h2A0, 12'h300, 12'h2A0 -> `lft_opn` = 1,1,0,0.
- Channel order checked: `a2d_chnl` = 3,0,3,0,3,0,3,0; `a2d_req` held through 10-cycle `a2d_rdy` delay; low exactly one cycle between requests.
- `en` dropped in SETTLE -> `IR_en` low next cycle, no `IR_vld`; dropped mid-REQ -> handshake completes, outputs unchanged.
- `rst` asserted mid-round -> all outputs at reset values immediately; next round completes normally.

Source files
------------

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared types and constants for the IR sense front end
package ir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_REQ    = 3'd2,
      ST_NEXT   = 3'd3,
      ST_DONE   = 3'd4
   } ir_state_e;

   localparam int         A2D_W          = 12;
   localparam logic [2:0] LFT_CHNL_DFLT  = 3'd3;
   localparam logic [2:0] RGHT_CHNL_DFLT = 3'd0;

endpackage

// File: rtl/ir_hyst.sv
// rtl/ir_hyst.sv - per-side open-wall flag with set/clear hysteresis
module ir_hyst
   import ir_pkg::*;
#(
   parameter logic [A2D_W-1:0] OPN_SET = 12'h200,
   parameter logic [A2D_W-1:0] OPN_CLR = 12'h300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd,
   input  logic [A2D_W-1:0] avg,
   output logic             opn
);

   logic opn_q;
   logic opn_d;

   // Between the thresholds the previous decision is kept.
   always_comb begin
      opn_d = opn_q;
      if (upd) begin
         if (avg < OPN_SET) begin
            opn_d = 1'b1;
         end else if (avg >= OPN_CLR) begin
            opn_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opn_q <= 1'b1;
      end else begin
         opn_q <= opn_d;
      end
   end

   assign opn = opn_q;

endmodule

// File: rtl/ir_sense.sv
// rtl/ir_sense.sv - IR emitter pulsing, A2D sampling, averaging and open-wall detect
module ir_sense
   import ir_pkg::*;
#(
   parameter int               PERIOD    = 1024,
   parameter int               SETTLE    = 64,
   parameter int               AVG_LOG2  = 2,
   parameter logic [2:0]       LFT_CHNL  = LFT_CHNL_DFLT,
   parameter logic [2:0]       RGHT_CHNL = RGHT_CHNL_DFLT,
   parameter logic [A2D_W-1:0] OPN_SET   = 12'h200,
   parameter logic [A2D_W-1:0] OPN_CLR   = 12'h300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             IR_en,
   output logic             a2d_req,
   output logic [2:0]       a2d_chnl,
   input  logic             a2d_rdy,
   input  logic [A2D_W-1:0] a2d_res,
   output logic [A2D_W-1:0] lft_IR,
   output logic [A2D_W-1:0] rght_IR,
   output logic             lft_opn,
   output logic             rght_opn,
   output logic             IR_vld
);

   localparam int PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int SW    = $clog2(SETTLE + 1);
   localparam int NCONV = 2 << AVG_LOG2;
   localparam int CW    = $clog2(NCONV + 1);
   localparam int AW    = A2D_W + AVG_LOG2;

   ir_state_e        state_q, state_d;
   logic [PW-1:0]    per_q, per_d;
   logic [SW-1:0]    set_q, set_d;
   logic [CW-1:0]    conv_q, conv_d;
   logic [AW-1:0]    lacc_q, lacc_d;
   logic [AW-1:0]    racc_q, racc_d;
   logic [2:0]       chnl_q, chnl_d;
   logic [A2D_W-1:0] lft_ir_q, lft_ir_d;
   logic [A2D_W-1:0] rght_ir_q, rght_ir_d;
   logic             vld_q, vld_d;

   logic             tick;
   logic             upd;
   logic             ir_en_c;
   logic             req_c;
   logic [A2D_W-1:0] lft_avg;
   logic [A2D_W-1:0] rght_avg;

   assign lft_avg  = lacc_q[AW-1:AVG_LOG2];
   assign rght_avg = racc_q[AW-1:AVG_LOG2];

   // Free-running round timer; parked at zero while disabled.
   always_comb begin
      per_d = per_q;
      tick  = 1'b0;
      if (!en) begin
         per_d = '0;
      end else if (per_q == PW'(PERIOD - 1)) begin
         per_d = '0;
         tick  = 1'b1;
      end else begin
         per_d = per_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      set_d     = set_q;
      conv_d    = conv_q;
      lacc_d    = lacc_q;
      racc_d    = racc_q;
      chnl_d    = chnl_q;
      lft_ir_d  = lft_ir_q;
      rght_ir_d = rght_ir_q;
      vld_d     = 1'b0;
      upd       = 1'b0;
      ir_en_c   = 1'b0;
      req_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_SETTLE;
               set_d   = '0;
               conv_d  = '0;
               lacc_d  = '0;
               racc_d  = '0;
            end
         end
         ST_SETTLE: begin
            ir_en_c = 1'b1;
            if (!en) begin
               state_d = ST_IDLE;
            end else if (set_q == SW'(SETTLE - 1)) begin
               state_d = ST_REQ;
               chnl_d  = LFT_CHNL;
            end else begin
               set_d = set_q + 1'b1;
            end
         end
         ST_REQ: begin
            // Even conversion indices are left, odd are right.
            ir_en_c = 1'b1;
            req_c   = 1'b1;
            if (a2d_rdy) begin
               if (!conv_q[0]) begin
                  lacc_d = lacc_q + AW'(a2d_res);
               end else begin
                  racc_d = racc_q + AW'(a2d_res);
               end
               conv_d  = conv_q + 1'b1;
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            ir_en_c = 1'b1;
            if (!en) begin
               state_d = ST_IDLE;
            end else if (conv_q == CW'(NCONV)) begin
               state_d   = ST_DONE;
               upd       = 1'b1;
               vld_d     = 1'b1;
               lft_ir_d  = lft_avg;
               rght_ir_d = rght_avg;
            end else begin
               state_d = ST_REQ;
               chnl_d  = conv_q[0] ? RGHT_CHNL : LFT_CHNL;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         per_q     <= '0;
         set_q     <= '0;
         conv_q    <= '0;
         lacc_q    <= '0;
         racc_q    <= '0;
         chnl_q    <= LFT_CHNL;
         lft_ir_q  <= '0;
         rght_ir_q <= '0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_q     <= per_d;
         set_q     <= set_d;
         conv_q    <= conv_d;
         lacc_q    <= lacc_d;
         racc_q    <= racc_d;
         chnl_q    <= chnl_d;
         lft_ir_q  <= lft_ir_d;
         rght_ir_q <= rght_ir_d;
         vld_q     <= vld_d;
      end
   end

   ir_hyst #(
      .OPN_SET (OPN_SET),
      .OPN_CLR (OPN_CLR)
   ) u_lft_hyst (
      .clk (clk),
      .rst (rst),
      .upd (upd),
      .avg (lft_avg),
      .opn (lft_opn)
   );

   ir_hyst #(
      .OPN_SET (OPN_SET),
      .OPN_CLR (OPN_CLR)
   ) u_rght_hyst (
      .clk (clk),
      .rst (rst),
      .upd (upd),
      .avg (rght_avg),
      .opn (rght_opn)
   );

   assign IR_en    = ir_en_c;
   assign a2d_req  = req_c;
   assign a2d_chnl = chnl_q;
   assign lft_IR   = lft_ir_q;
   assign rght_IR  = rght_ir_q;
   assign IR_vld   = vld_q;

endmodule

// File: tb/tb_ir_sense.sv
// tb/tb_ir_sense.sv - directed bench for ir_sense with a handshaking A2D model
module tb_ir_sense;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        a2d_rdy = 1'b0;
   logic [11:0] a2d_res = 12'h000;
   logic        IR_en;
   logic        a2d_req;
   logic [2:0]  a2d_chnl;
   logic [11:0] lft_IR;
   logic [11:0] rght_IR;
   logic        lft_opn;
   logic        rght_opn;
   logic        IR_vld;

   ir_sense u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .IR_en    (IR_en),
      .a2d_req  (a2d_req),
      .a2d_chnl (a2d_chnl),
      .a2d_rdy  (a2d_rdy),
      .a2d_res  (a2d_res),
      .lft_IR   (lft_IR),
      .rght_IR  (rght_IR),
      .lft_opn  (lft_opn),
      .rght_opn (rght_opn),
      .IR_vld   (IR_vld)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A2D model: answers each request k cycles later, per-side sample tables
   int          k = 3;
   logic [11:0] lft_s [4];
   logic [11:0] rgt_s [4];
   int          li = 0, ri = 0, wcnt = 0, last_rdy = 0, first_req = -1;
   int          n_rdy = 0, req_drop = 0, gap_err = 0;
   bit          pend = 0, have_rdy = 0, ir_en_prev = 0;
   logic [2:0]  chnl_cur = 3'd0;
   logic [23:0] chnl_sh = 24'h0;

   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         pend    = 0;
         a2d_rdy = 1'b0;
      end else begin
         if (IR_en && !ir_en_prev) begin
            li = 0; ri = 0; chnl_sh = 24'h0; have_rdy = 0; first_req = -1;
         end
         if (a2d_rdy) begin
            a2d_rdy = 1'b0;
            pend    = 0;
         end else if (pend) begin
            if (!a2d_req || a2d_chnl != chnl_cur) req_drop++;
            wcnt++;
            if (wcnt >= k) begin
               a2d_rdy  = 1'b1;
               last_rdy = cyc;
               have_rdy = 1;
               n_rdy++;
               if (chnl_cur == 3'd3) begin
                  a2d_res = lft_s[li % 4];
                  li++;
               end else begin
                  a2d_res = rgt_s[ri % 4];
                  ri++;
               end
            end
         end else if (a2d_req) begin
            pend     = 1;
            wcnt     = 0;
            chnl_cur = a2d_chnl;
            chnl_sh  = {chnl_sh[20:0], a2d_chnl};
            if (first_req < 0) first_req = cyc;
            if (have_rdy && (cyc - last_rdy) != 2) gap_err++;
         end
      end
      ir_en_prev = IR_en;
   end

   task automatic set_samples(input logic [11:0] l0, l1, l2, l3, input logic [11:0] r);
      lft_s[0] = l0; lft_s[1] = l1; lft_s[2] = l2; lft_s[3] = l3;
      for (int i = 0; i < 4; i++) rgt_s[i] = r;
   endtask

   task automatic wait_vld(input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         @(posedge clk);
         #1;
         if (IR_vld) begin
            at = cyc;
            break;
         end
      end
      check_eq("vld_seen", at >= 0, 1'b1);
   endtask

   task automatic count_vld(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (IR_vld) cnt++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_ir_en"}, IR_en, 1'b0);
      check_eq({tag, "_req"}, a2d_req, 1'b0);
      check_eq({tag, "_chnl"}, a2d_chnl, 3'd3);
      check_eq({tag, "_lft"}, lft_IR, 12'h000);
      check_eq({tag, "_rght"}, rght_IR, 12'h000);
      check_eq({tag, "_lopn"}, lft_opn, 1'b1);
      check_eq({tag, "_ropn"}, rght_opn, 1'b1);
      check_eq({tag, "_vld"}, IR_vld, 1'b0);
   endtask

   logic [11:0] hyst_v [4];
   logic        hyst_e [4];

   initial begin
      int c0, t, cnt, nr;
      hyst_v[0] = 12'h1FF; hyst_v[1] = 12'h2A0; hyst_v[2] = 12'h300; hyst_v[3] = 12'h2A0;
      hyst_e[0] = 1'b1;    hyst_e[1] = 1'b1;    hyst_e[2] = 1'b0;    hyst_e[3] = 1'b0;
      set_samples(12'h800, 12'h800, 12'h800, 12'h800, 12'h800);

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;

      // Round A: flat 0x800, k=3
      @(posedge clk);
      #1;
      k  = 3;
      c0 = cyc;
      en = 1'b1;
      wait_vld(1300, t);
      check_eq("a_vld_cyc", t, c0 + 1128);
      check_eq("a_first_req", first_req, c0 + 1088);
      check_eq("a_lft", lft_IR, 12'h800);
      check_eq("a_rght", rght_IR, 12'h800);
      check_eq("a_lopn", lft_opn, 1'b0);
      check_eq("a_ropn", rght_opn, 1'b0);
      check_eq("a_chnl_seq", chnl_sh, 24'h618618);
      check_eq("a_ir_en_done", IR_en, 1'b0);
      @(posedge clk);
      #1;
      check_eq("a_vld_pulse", IR_vld, 1'b0);

      // Round B: truncating average, 10-cycle rdy delay
      k = 10;
      set_samples(12'h100, 12'h101, 12'h102, 12'h103, 12'h250);
      wait_vld(1300, t);
      check_eq("b_lft", lft_IR, 12'h101);
      check_eq("b_lopn", lft_opn, 1'b1);
      check_eq("b_rght", rght_IR, 12'h250);
      check_eq("b_ropn_hold", rght_opn, 1'b0);
      check_eq("b_chnl_seq", chnl_sh, 24'h618618);
      check_eq("b_req_hold", req_drop, 0);
      check_eq("b_req_gap", gap_err, 0);

      // Hysteresis sweep on the left side
      k = 3;
      for (int i = 0; i < 4; i++) begin
         set_samples(hyst_v[i], hyst_v[i], hyst_v[i], hyst_v[i], 12'h800);
         wait_vld(1300, t);
         check_eq($sformatf("hyst%0d_lft", i), lft_IR, hyst_v[i]);
         check_eq($sformatf("hyst%0d_lopn", i), lft_opn, hyst_e[i]);
      end

      // en dropped during SETTLE
      set_samples(12'h050, 12'h050, 12'h050, 12'h050, 12'h050);
      t = -1;
      for (int i = 0; i < 1300; i++) begin
         @(posedge clk);
         #1;
         if (IR_en) begin
            t = cyc;
            break;
         end
      end
      check_eq("s_ir_en_seen", t >= 0, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      en = 1'b0;
      @(posedge clk);
      #1;
      check_eq("s_ir_en_off", IR_en, 1'b0);
      count_vld(300, cnt);
      check_eq("s_no_vld", cnt, 0);
      check_eq("s_lft_kept", lft_IR, 12'h2A0);

      // en dropped mid-REQ: handshake finishes, no update
      en = 1'b1;
      t  = -1;
      for (int i = 0; i < 1300; i++) begin
         @(posedge clk);
         #1;
         if (a2d_req) begin
            t = cyc;
            break;
         end
      end
      check_eq("r_req_seen", t >= 0, 1'b1);
      nr = n_rdy;
      en = 1'b0;
      count_vld(20, cnt);
      check_eq("r_no_vld", cnt, 0);
      check_eq("r_rdy_done", n_rdy - nr, 1);
      check_eq("r_ir_en_off", IR_en, 1'b0);
      check_eq("r_req_off", a2d_req, 1'b0);
      check_eq("r_lft_kept", lft_IR, 12'h2A0);
      check_eq("r_lopn_kept", lft_opn, 1'b0);
      check_eq("r_req_hold", req_drop, 0);
      check_eq("r_req_gap", gap_err, 0);

      // rst mid-round, then a clean round
      set_samples(12'h800, 12'h800, 12'h800, 12'h800, 12'h800);
      en = 1'b1;
      t  = -1;
      for (int i = 0; i < 1300; i++) begin
         @(posedge clk);
         #1;
         if (a2d_req) begin
            t = cyc;
            break;
         end
      end
      check_eq("x_req_seen", t >= 0, 1'b1);
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_vals("x_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      c0  = cyc;
      wait_vld(1300, t);
      check_eq("x_vld_cyc", t, c0 + 1128);
      check_eq("x_lft", lft_IR, 12'h800);
      check_eq("x_rght", rght_IR, 12'h800);
      check_eq("x_lopn", lft_opn, 1'b0);
      check_eq("x_ropn", rght_opn, 1'b0);
      check_eq("x_chnl_seq", chnl_sh, 24'h618618);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
